// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that shares one sequential multiplier between NREQ
// requesters. One operation is in flight at a time: accept, start, wait for
// the finish pulse, then hand the product back to the originating requester.
module mul_share_arbiter #(
  parameter int LEN   = 32,
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*LEN-1:0]   req_a,
  input  logic [NREQ*LEN-1:0]   req_b,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [2*LEN-1:0]      resp_product,
  output logic                  busy,
  output logic                  mul_start,
  output logic [LEN-1:0]        mul_multiplicand,
  output logic [LEN-1:0]        mul_multiplier,
  input  logic [2*LEN-1:0]      mul_product,
  input  logic                  mul_finish
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [LEN-1:0]     opa_q, opa_d;
  logic [LEN-1:0]     opb_q, opb_d;
  logic [2*LEN-1:0]   result_q, result_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  int                 cand;
  logic [IDX_W-1:0]   cand_idx;

  // Round-robin scan: first valid requester starting just after the last grant.
  // A requester that was just served is therefore considered last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(last_grant_q) + k) % NREQ;
      cand_idx = IDX_W'(cand);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state logic and handshake outputs for the accept/issue/wait/respond FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    result_d     = result_q;
    req_ready    = '0;
    resp_valid   = '0;
    mul_start    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          req_ready[pick_idx] = 1'b1;
          grant_d             = pick_idx;
          opa_d               = req_a[int'(pick_idx)*LEN +: LEN];
          opb_d               = req_b[int'(pick_idx)*LEN +: LEN];
          state_d             = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // No timeout: completion is signalled only by the multiplier.
        if (mul_finish) begin
          result_d = mul_product;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid[grant_q] = 1'b1;
        if (resp_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A requester must never see an acceptance that reset is about to discard.
    if (rst) begin
      req_ready = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDX_W'(NREQ - 1);
      grant_q      <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      result_q     <= result_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign resp_product     = result_q;
  assign mul_multiplicand = opa_q;
  assign mul_multiplier   = opb_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural shift-add
// multiplier timing model (start, LEN work cycles, one finish cycle).
module tb_mul_share_arbiter;

  localparam int LEN  = 32;
  localparam int NREQ = 4;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*LEN-1:0]  req_a;
  logic [NREQ*LEN-1:0]  req_b;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [2*LEN-1:0]     resp_product;
  logic                 busy;
  logic                 mul_start;
  logic [LEN-1:0]       mul_multiplicand;
  logic [LEN-1:0]       mul_multiplier;
  logic [2*LEN-1:0]     mul_product;
  logic                 mul_finish;

  logic                 stray;
  logic                 mfin;
  logic                 mbusy;
  logic [7:0]           mcnt;
  logic [2*LEN-1:0]     mprod;

  int checks = 0;
  int errors = 0;

  mul_share_arbiter #(.LEN(LEN), .NREQ(NREQ)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_a            (req_a),
    .req_b            (req_b),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_product     (resp_product),
    .busy             (busy),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product),
    .mul_finish       (mul_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: finish pulses LEN+1 cycles after the start cycle.
  always @(posedge clk) begin
    if (rst) begin
      mbusy <= 1'b0;
      mfin  <= 1'b0;
      mcnt  <= '0;
      mprod <= '0;
    end else begin
      mfin <= 1'b0;
      if (mul_start) begin
        mbusy <= 1'b1;
        mcnt  <= 8'(LEN);
        mprod <= {32'b0, mul_multiplicand} * {32'b0, mul_multiplier};
      end else if (mbusy) begin
        if (mcnt == 8'd1) begin
          mfin  <= 1'b1;
          mbusy <= 1'b0;
        end else begin
          mcnt <= mcnt - 8'd1;
        end
      end
    end
  end

  assign mul_product = mprod;
  assign mul_finish  = mfin | stray;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*LEN +: LEN] = a;
    req_b[i*LEN +: LEN] = b;
  endtask

  task automatic wait_resp(input string tag);
    for (int n = 0; n < 100; n++) begin
      if (resp_valid != '0) break;
      tick();
    end
    chk({tag, "_timeout"}, 64'(resp_valid != '0), 64'd1);
  endtask

  // One complete transaction: grant in this cycle, then response handshake.
  task automatic do_txn(input string tag, input int idx, input logic [63:0] prod);
    #1;
    chk({tag, "_grant"}, 64'(req_ready), 64'(4'b0001 << idx));
    tick();
    wait_resp(tag);
    chk({tag, "_rvalid"}, 64'(resp_valid), 64'(4'b0001 << idx));
    chk({tag, "_prod"}, resp_product, prod);
    resp_ready = 4'b0001 << idx;
    tick();
    resp_ready = '0;
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;
    stray      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mul_start", 64'(mul_start), 64'd0);
    chk("rst_product", resp_product, 64'd0);
    chk("rst_opa", 64'(mul_multiplicand), 64'd0);

    // Single requester 2: 7 * 9, latency and held response.
    set_req(2, 32'd7, 32'd9);
    req_valid = 4'b0100;
    #1;
    chk("t1_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    chk("t1_start", 64'(mul_start), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_opa", 64'(mul_multiplicand), 64'd7);
    chk("t1_opb", 64'(mul_multiplier), 64'd9);
    tick();
    chk("t1_start_once", 64'(mul_start), 64'd0);
    for (int n = 0; n < 32; n++) tick();
    chk("t1_not_early", 64'(resp_valid), 64'd0);
    tick();
    chk("t1_rvalid_T35", 64'(resp_valid), 64'b0100);
    chk("t1_prod", resp_product, 64'd63);
    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk("t1_stray_resp_valid", 64'(resp_valid), 64'b0100);
    chk("t1_stray_resp_prod", resp_product, 64'd63);
    tick();
    tick();
    chk("t1_hold_valid", 64'(resp_valid), 64'b0100);
    chk("t1_hold_prod", resp_product, 64'd63);
    resp_ready = 4'b0100;
    tick();
    resp_ready = '0;
    chk("t1_done_valid", 64'(resp_valid), 64'd0);
    chk("t1_done_busy", 64'(busy), 64'd0);
    stray = 1'b1;
    tick();
    stray = 1'b0;
    chk("t1_stray_idle_busy", 64'(busy), 64'd0);
    chk("t1_stray_idle_prod", resp_product, 64'd63);

    // Reset so requester 0 leads, then all four contend.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'd1000);
    req_valid = 4'b1111;
    do_txn("rr0", 0, 64'd1000);
    do_txn("rr1", 1, 64'd2000);
    do_txn("rr2", 2, 64'd3000);
    do_txn("rr3", 3, 64'd4000);
    do_txn("rr0b", 0, 64'd1000);
    req_valid = '0;

    // Full-width corners (last grant is 0, so 3 then 1 by single valids).
    set_req(3, 32'd0, 32'hDEAD_BEEF);
    req_valid = 4'b1000;
    do_txn("zero", 3, 64'd0);
    set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    req_valid = 4'b0010;
    do_txn("full", 1, 64'hFFFF_FFFE_0000_0001);
    req_valid = '0;

    // Reset while waiting on the multiplier.
    set_req(2, 32'd3, 32'd4);
    req_valid = 4'b0100;
    #1;
    chk("w_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("w_rst_ready", 64'(req_ready), 64'd0);
    chk("w_rst_rvalid", 64'(resp_valid), 64'd0);
    chk("w_rst_busy", 64'(busy), 64'd0);
    chk("w_rst_start", 64'(mul_start), 64'd0);
    chk("w_rst_prod", resp_product, 64'd0);
    chk("w_rst_opa", 64'(mul_multiplicand), 64'd0);
    chk("w_rst_opb", 64'(mul_multiplier), 64'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
        if (resp_valid != '0) seen = 1'b1;
        tick();
      end
      chk("w_no_resp", 64'(seen), 64'd0);
    end
    set_req(0, 32'd5, 32'd6);
    set_req(3, 32'd2, 32'd2);
    req_valid = 4'b1001;
    do_txn("w_first0", 0, 64'd30);
    req_valid = '0;

    // Requester 1 with resp_ready tied high; requester 2 also waiting.
    set_req(1, 32'd11, 32'd12);
    set_req(2, 32'd13, 32'd3);
    req_valid  = 4'b0110;
    resp_ready = 4'b0010;
    #1;
    chk("tie_grant", 64'(req_ready), 64'b0010);
    tick();
    wait_resp("tie");
    chk("tie_rvalid", 64'(resp_valid), 64'b0010);
    chk("tie_prod", resp_product, 64'd132);
    tick();
    chk("tie_one_cycle", 64'(resp_valid), 64'd0);
    chk("tie_next_grant", 64'(req_ready), 64'b0100);
    req_valid  = 4'b0100;
    resp_ready = '0;
    do_txn("tie2", 2, 64'd39);
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
